// File: rtl/beam_accumulator.sv
// Purpose: sums NUM_ELEMENTS good samples per beam point over a scan of POINTS points.
// Latency: beam_valid/beam_value/point_index register one cycle after the final sample of a point.
// Backpressure: none; every sample_good cycle in ACCUM is accepted, and dropping start aborts the scan.
module beam_accumulator #(
    parameter int NUM_ELEMENTS = 64,
    parameter int POINTS       = 1024,
    parameter int ACC_WIDTH    = 48
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [31:0]          sample_value,
    input  logic                 sample_good,
    output logic [ACC_WIDTH-1:0] beam_value,
    output logic                 beam_valid,
    output logic [15:0]          point_index,
    output logic                 busy,
    output logic                 scan_done,
    output logic                 overflow
);

    localparam int EW = $clog2(NUM_ELEMENTS);
    localparam logic [EW-1:0] LAST_ELEM  = EW'(NUM_ELEMENTS - 1);
    localparam logic [15:0]   LAST_POINT = 16'(POINTS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [EW-1:0]          elem_cnt_q, elem_cnt_d;
    logic [15:0]            point_cnt_q, point_cnt_d;
    logic [ACC_WIDTH-1:0]   beam_value_q, beam_value_d;
    logic                   beam_valid_q, beam_valid_d;
    logic [15:0]            point_index_q, point_index_d;
    logic                   busy_q, busy_d;
    logic                   scan_done_q, scan_done_d;
    logic                   overflow_q, overflow_d;

    logic [ACC_WIDTH-1:0]   sample_ext;
    logic [ACC_WIDTH-1:0]   sum;
    logic                   add_ovf;

    // Sign-extend the sample, form the wrapped sum and detect signed overflow of that add
    always_comb begin
        sample_ext = {{(ACC_WIDTH-32){sample_value[31]}}, sample_value};
        sum        = acc_q + sample_ext;
        add_ovf    = (acc_q[ACC_WIDTH-1] == sample_ext[ACC_WIDTH-1]) &&
                     (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
    end

    // Next-state and datapath update; abort on start low wins over point completion
    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        elem_cnt_d    = elem_cnt_q;
        point_cnt_d   = point_cnt_q;
        beam_value_d  = beam_value_q;
        beam_valid_d  = 1'b0;
        point_index_d = point_index_q;
        overflow_d    = overflow_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = ACCUM;
                    acc_d       = '0;
                    elem_cnt_d  = '0;
                    point_cnt_d = '0;
                    overflow_d  = 1'b0;
                end
            end
            ACCUM: begin
                if (!start) begin
                    state_d    = IDLE;
                    acc_d      = '0;
                    elem_cnt_d = '0;
                end else if (sample_good) begin
                    overflow_d = overflow_q | add_ovf;
                    if (elem_cnt_q == LAST_ELEM) begin
                        beam_value_d  = sum;
                        beam_valid_d  = 1'b1;
                        point_index_d = point_cnt_q;
                        acc_d         = '0;
                        elem_cnt_d    = '0;
                        point_cnt_d   = point_cnt_q + 16'd1;
                        if (point_cnt_q == LAST_POINT) begin
                            state_d = DONE;
                        end
                    end else begin
                        acc_d      = sum;
                        elem_cnt_d = elem_cnt_q + EW'(1);
                    end
                end
            end
            DONE: begin
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d      = (state_d == ACCUM);
        scan_done_d = (state_d == DONE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            acc_q         <= '0;
            elem_cnt_q    <= '0;
            point_cnt_q   <= '0;
            beam_value_q  <= '0;
            beam_valid_q  <= 1'b0;
            point_index_q <= '0;
            busy_q        <= 1'b0;
            scan_done_q   <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            elem_cnt_q    <= elem_cnt_d;
            point_cnt_q   <= point_cnt_d;
            beam_value_q  <= beam_value_d;
            beam_valid_q  <= beam_valid_d;
            point_index_q <= point_index_d;
            busy_q        <= busy_d;
            scan_done_q   <= scan_done_d;
            overflow_q    <= overflow_d;
        end
    end

    assign beam_value  = beam_value_q;
    assign beam_valid  = beam_valid_q;
    assign point_index = point_index_q;
    assign busy        = busy_q;
    assign scan_done   = scan_done_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_beam_accumulator.sv
// Purpose: scoreboard bench for beam_accumulator at 48-bit and 33-bit accumulator widths.
// Latency: expected strobes are queued at stimulus time and popped when beam_valid is seen.
// Backpressure: none; an unexpected strobe or a leftover expectation is a failure.
module tb_beam_accumulator;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] sample_value;
    logic        sample_good;

    logic [47:0] bv_a;
    logic        vld_a;
    logic [15:0] idx_a;
    logic        busy_a, done_a, ovf_a;

    logic [32:0] bv_b;
    logic        vld_b;
    logic [15:0] idx_b;
    logic        busy_b, done_b, ovf_b;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] exp_val_a[$];
    logic [15:0] exp_idx_a[$];
    logic [63:0] exp_val_b[$];
    logic [15:0] exp_idx_b[$];

    always #5 clk = ~clk;

    beam_accumulator #(.NUM_ELEMENTS(4), .POINTS(3), .ACC_WIDTH(48)) dut_a (
        .clk(clk), .reset(reset), .start(start),
        .sample_value(sample_value), .sample_good(sample_good),
        .beam_value(bv_a), .beam_valid(vld_a), .point_index(idx_a),
        .busy(busy_a), .scan_done(done_a), .overflow(ovf_a)
    );

    beam_accumulator #(.NUM_ELEMENTS(4), .POINTS(3), .ACC_WIDTH(33)) dut_b (
        .clk(clk), .reset(reset), .start(start),
        .sample_value(sample_value), .sample_good(sample_good),
        .beam_value(bv_b), .beam_valid(vld_b), .point_index(idx_b),
        .busy(busy_b), .scan_done(done_b), .overflow(ovf_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One good sample for one cycle, then the bus goes quiet
    task automatic send(input int v);
        sample_value = v;
        sample_good  = 1'b1;
        tick();
        sample_good  = 1'b0;
    endtask

    task automatic expect_point(input longint v, input int idx);
        exp_val_a.push_back(64'(v));
        exp_idx_a.push_back(16'(idx));
        exp_val_b.push_back(64'(v));
        exp_idx_b.push_back(16'(idx));
    endtask

    task automatic restart();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
    endtask

    // Scoreboard for the 48-bit instance
    always @(negedge clk) begin
        if (vld_a) begin
            if (exp_val_a.size() == 0) begin
                check("a_unexpected_strobe", 64'd1, 64'd0);
            end else begin
                logic [63:0] ev;
                logic [15:0] ei;
                ev = exp_val_a.pop_front();
                ei = exp_idx_a.pop_front();
                check("a_beam_value", {16'd0, bv_a}, {16'd0, ev[47:0]});
                check("a_point_index", {48'd0, idx_a}, {48'd0, ei});
            end
        end
    end

    // Scoreboard for the 33-bit instance
    always @(negedge clk) begin
        if (vld_b) begin
            if (exp_val_b.size() == 0) begin
                check("b_unexpected_strobe", 64'd1, 64'd0);
            end else begin
                logic [63:0] ev;
                logic [15:0] ei;
                ev = exp_val_b.pop_front();
                ei = exp_idx_b.pop_front();
                check("b_beam_value", {31'd0, bv_b}, {31'd0, ev[32:0]});
                check("b_point_index", {48'd0, idx_b}, {48'd0, ei});
            end
        end
    end

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        sample_value = '0;
        sample_good  = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_beam_value", {16'd0, bv_a}, 64'd0);
        check("rst_valid", {63'd0, vld_a}, 64'd0);
        check("rst_index", {48'd0, idx_a}, 64'd0);
        check("rst_busy", {63'd0, busy_a}, 64'd0);
        check("rst_done", {63'd0, done_a}, 64'd0);
        check("rst_ovf", {63'd0, ovf_a}, 64'd0);

        // Basic point: 10 - 3 + 7 + 100 = 114
        reset = 1'b0;
        start = 1'b1;
        tick();
        check("busy_in_accum", {63'd0, busy_a}, 64'd1);
        expect_point(114, 0);
        send(10); send(-3); send(7); send(100);
        check("strobe_latency", {63'd0, vld_a}, 64'd1);
        tick();
        check("strobe_one_cycle", {63'd0, vld_a}, 64'd0);
        tick(); tick();
        check("hold_value", {16'd0, bv_a}, 64'd114);
        check("hold_index", {48'd0, idx_a}, 64'd0);

        // Full scan with random gaps: three points of four ones
        restart();
        for (int p = 0; p < 3; p++) expect_point(4, p);
        for (int i = 0; i < 12; i++) begin
            send(1);
            repeat ($urandom_range(0, 3)) tick();
        end
        tick();
        check("scan_done", {63'd0, done_a}, 64'd1);
        check("busy_after_done", {63'd0, busy_a}, 64'd0);
        for (int i = 0; i < 8; i++) send(1);
        check("done_ignores_samples", {63'd0, done_a}, 64'd1);

        // Abort partway through a point, then a clean point of fives
        restart();
        send(9); send(9);
        start = 1'b0;
        tick();
        check("abort_idle", {63'd0, busy_a}, 64'd0);
        start = 1'b1;
        tick();
        expect_point(20, 0);
        for (int i = 0; i < 4; i++) send(5);

        // Start falls together with the final sample: abort wins
        restart();
        send(3); send(3); send(3);
        start = 1'b0;
        send(3);
        check("simul_no_valid", {63'd0, vld_a}, 64'd0);
        check("simul_idle_busy", {63'd0, busy_a}, 64'd0);
        check("simul_idle_done", {63'd0, done_a}, 64'd0);

        // Overflow: 4 x 0x7FFFFFFF wraps in 33 bits, fits in 48 bits
        start = 1'b1;
        tick();
        expect_point(64'h1_FFFF_FFFC, 0);
        for (int i = 0; i < 4; i++) send(32'h7FFF_FFFF);
        check("ovf_b_set", {63'd0, ovf_b}, 64'd1);
        check("ovf_a_clear", {63'd0, ovf_a}, 64'd0);
        start = 1'b0;
        tick(); tick();
        check("ovf_b_sticky", {63'd0, ovf_b}, 64'd1);
        start = 1'b1;
        tick();
        check("ovf_b_cleared", {63'd0, ovf_b}, 64'd0);

        // Reset mid-point, then a point of -2s right after release
        send(1); send(1); send(1);
        reset = 1'b1;
        tick();
        check("mid_rst_value", {16'd0, bv_a}, 64'd0);
        check("mid_rst_valid", {63'd0, vld_a}, 64'd0);
        check("mid_rst_busy", {63'd0, busy_a}, 64'd0);
        check("mid_rst_b_value", {31'd0, bv_b}, 64'd0);
        reset = 1'b0;
        tick();
        check("accum_after_rst", {63'd0, busy_a}, 64'd1);
        expect_point(-8, 0);
        for (int i = 0; i < 4; i++) send(-2);

        repeat (4) tick();
        check("a_queue_drained", 64'(exp_val_a.size()), 64'd0);
        check("b_queue_drained", 64'(exp_val_b.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
